// File: rtl/key_debounce_strobe.sv
// key_debounce_strobe: 2-flop sync + per-key debounce for 4 active-low keys.
// Ports: clk, rst (async, active-high), key_in[3:0] raw pins (0 = pressed),
//   key_value[3:0] debounced levels (0 = pressed), flag[3:0] one-cycle strobes.
// Optional macro KEY_REPEAT_EN adds auto-repeat strobes on held keys.
module key_debounce_strobe #(
  parameter int CNT_MAX       = 999_999,
  parameter int REPEAT_DELAY  = 24_999_999,
  parameter int REPEAT_PERIOD = 9_999_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  output logic [3:0] key_value,
  output logic [3:0] flag
);

  localparam logic [23:0] CMAX = 24'(CNT_MAX);

  if (CNT_MAX < 1 || CNT_MAX > 24'hFF_FFFF ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_param_chk
    $error("key_debounce_strobe: illegal parameter set");
  end

  logic [3:0] s1;
  logic [3:0] ks;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 4'hF;
      ks <= 4'hF;
    end else begin
      s1 <= key_in;
      ks <= s1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_key
    logic [23:0] dcnt;
    logic        kv;
    logic        fl;
    logic        acc;
    logic        rep;

    // Window complete and the synced level still differs: accept.
    assign acc = (ks[i] != kv) && (dcnt >= CMAX);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dcnt <= '0;
        kv   <= 1'b1;
        fl   <= 1'b0;
      end else begin
        fl <= acc | rep;
        if (ks[i] == kv) begin
          dcnt <= '0;
        end else if (dcnt < CMAX) begin
          dcnt <= dcnt + 24'd1;
        end else begin
          kv   <= ks[i];
          dcnt <= '0;
        end
      end
    end

`ifdef KEY_REPEAT_EN
    localparam logic [26:0] RD1 = 27'(REPEAT_DELAY - 1);
    localparam logic [26:0] RRL = 27'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [26:0] rcnt;

    // Strobe lands in the cycle rcnt reaches REPEAT_DELAY; reload so the
    // next one is REPEAT_PERIOD cycles later.
    assign rep = !acc && !kv && !ks[i] && (rcnt == RD1);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rcnt <= '0;
      end else if (acc || kv || ks[i]) begin
        rcnt <= '0;
      end else if (rcnt == RD1) begin
        rcnt <= RRL;
      end else begin
        rcnt <= rcnt + 27'd1;
      end
    end
`else
    assign rep = 1'b0;
`endif

    assign key_value[i] = kv;
    assign flag[i]      = fl;
  end

endmodule

// File: tb/tb_key_debounce_strobe.sv
// tb_key_debounce_strobe: directed + random stimulus for key_debounce_strobe,
// checked cycle by cycle against a behavioural key model.
module tb_key_debounce_strobe;

  localparam int CM = 9;
  localparam int RD = 30;
  localparam int RP = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_in = 4'hF;
  logic [3:0] key_value;
  logic [3:0] flag;

  int n_cmp = 0;
  int n_err = 0;

  key_debounce_strobe #(
    .CNT_MAX(CM),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .key_value(key_value),
    .flag(flag)
  );

  always #5 clk = ~clk;

  // Model: synced sample = raw from two edges ago; a level is accepted
  // once CM+1 consecutive synced samples disagree with it.
  logic [3:0] p1 = 4'hF;
  logic [3:0] p2 = 4'hF;
  logic [3:0] lv = 4'hF;
  logic [3:0] ef = 4'h0;
  int run[4];
  int hold[4];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic s;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        p1[i] = 1'b1; p2[i] = 1'b1; lv[i] = 1'b1; ef[i] = 1'b0;
        run[i] = 0; hold[i] = 0;
      end else begin
        s = p2[i];
        p2[i] = p1[i];
        p1[i] = key_in[i];
        ef[i] = 1'b0;
        if (s != lv[i]) begin
          run[i]++;
          if (run[i] == CM + 1) begin
            lv[i] = s; ef[i] = 1'b1; run[i] = 0; hold[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
`ifdef KEY_REPEAT_EN
        if (!ef[i]) begin
          if (s || lv[i]) hold[i] = 0;
          else begin
            hold[i]++;
            if (hold[i] >= RD && ((hold[i] - RD) % RP) == 0) ef[i] = 1'b1;
          end
        end
`endif
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("key_value", key_value, lv);
    chk("flag", flag, ef);
  endtask

  task automatic steps(input int n, output int nf);
    nf = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (flag != 4'h0) nf++;
    end
  endtask

  task automatic wait_flag(input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (flag == 4'h0 && n < maxc);
  endtask

  int n;
  int nf;
  int seg[4];

  initial begin
    steps(3, nf);
    chk("rst_kv", key_value, 4'hF);
    chk("rst_flag", flag, 4'h0);
    rst = 1'b0;
    steps(4, nf);

    // clean press / release on key 1
    key_in[1] = 1'b0;
    wait_flag(40, n);
    chk("press_lat", n, 12);
    chk("press_flag", flag, 4'b0010);
    key_in[1] = 1'b1;
    wait_flag(40, n);
    chk("release_lat", n, 12);
    chk("release_kv", key_value, 4'hF);
    steps(5, nf);

    // bounce on key 2
    nf = 0;
    for (int b = 0; b < 4; b++) begin
      int f;
      key_in[2] = (b % 2) ? 1'b1 : 1'b0;
      steps(3, f);
      nf += f;
    end
    chk("bounce_quiet", nf, 0);
    key_in[2] = 1'b0;
    wait_flag(40, n);
    chk("bounce_lat", n, 12);
    chk("bounce_flag", flag, 4'b0100);
    key_in[2] = 1'b1;
    steps(30, nf);

    // glitch on key 0
    key_in[0] = 1'b0;
    steps(8, nf);
    key_in[0] = 1'b1;
    begin
      int f2;
      steps(20, f2);
      chk("glitch_quiet", nf + f2, 0);
    end
    chk("glitch_kv", key_value, 4'hF);

    // simultaneous keys 3 and 0
    key_in = 4'b0110;
    wait_flag(40, n);
    chk("simul_lat", n, 12);
    chk("simul_flag", flag, 4'b1001);
    steps(19, nf);
    key_in = 4'hF;
    wait_flag(40, n);
    chk("simul_rel_flag", flag, 4'b1001);
    chk("simul_rel_kv", key_value, 4'hF);
    steps(5, nf);

    // reset in the middle of a press window
    key_in[2] = 1'b0;
    steps(7, nf);
    rst = 1'b1;
    #1;
    chk("midrst_kv", key_value, 4'hF);
    chk("midrst_flag", flag, 4'h0);
    steps(2, nf);
    rst = 1'b0;
    wait_flag(40, n);
    chk("midrst_lat", n, 12);
    chk("midrst_flag2", flag, 4'b0100);
    key_in[2] = 1'b1;
    steps(30, nf);

`ifdef KEY_REPEAT_EN
    key_in[1] = 1'b0;
    wait_flag(40, n);
    chk("rep_press_lat", n, 12);
    wait_flag(60, n);
    chk("rep_first", n, RD);
    chk("rep_kv", key_value, 4'b1101);
    wait_flag(40, n);
    chk("rep_period1", n, RP);
    wait_flag(40, n);
    chk("rep_period2", n, RP);
    key_in[1] = 1'b1;
    wait_flag(40, n);
    chk("rep_release_lat", n, 12);
    chk("rep_release_kv", key_value, 4'hF);
    steps(60, nf);
    chk("rep_quiet", nf, 0);
`endif

    // randomized segments per key, with a reset mid-run
    for (int i = 0; i < 4; i++) seg[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (seg[i] == 0) begin
          key_in[i] = 1'($urandom_range(0, 1));
          seg[i] = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 12)
                                               : $urandom_range(13, 90);
        end
        seg[i]--;
      end
      rst = (c >= 1500 && c < 1503) ? 1'b1 : 1'b0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
